sram_arbiter: RTL and testbench

- Shares the single cartridge SRAM (ROM/SaveRAM/BS-X PSRAM space) between two requesters:
  - the SNES bus path, which supplies the already-translated ROM_ADDR and IS_WRITABLE from the address decoder;
  - the MCU/DMA port.
- Sequences each access with fixed setup and strobe timing, and inserts recovery cycles between accesses.
- SNES has strict priority. One SNES request that arrives during a busy access is buffered.
- Sits between the address decoder and the SRAM pad drivers.

---
 rtl/sram_arbiter_pkg.sv | 27 ++
 rtl/sram_arbiter_if.sv | 41 ++++
 rtl/sram_arbiter_access_seq.sv | 132 +++++++++++++
 rtl/sram_arbiter.sv | 102 ++++++++++
 tb/tb_sram_arbiter.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/sram_arbiter_pkg.sv
// Shared definitions for the cartridge SRAM arbiter: FSM encoding, owner IDs,
// default timing and the captured-request record.
package sram_arb_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ACCESS  = 2'd1;
  localparam logic [1:0] ST_RECOVER = 2'd2;

  localparam logic OWN_SNES = 1'b0;
  localparam logic OWN_MCU  = 1'b1;

  localparam int ACCESS_CYCLES_DEF  = 4;
  localparam int RECOVER_CYCLES_DEF = 1;

  // wr_en is the write that actually reaches the pads (we gated by IS_WRITABLE).
  typedef struct packed {
    logic [23:0] addr;
    logic [7:0]  wdata;
    logic        we;
    logic        wr_en;
  } acc_req_t;

  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sram_arbiter_if.sv
// Requester and SRAM pad signals of the arbiter, bundled with directional modports.
interface sram_arbiter_if;
  logic        snes_req;
  logic        snes_we;
  logic        snes_writable;
  logic [23:0] snes_addr;
  logic [7:0]  snes_wdata;
  logic [7:0]  snes_rdata;
  logic        snes_done;
  logic        mcu_req;
  logic        mcu_we;
  logic [23:0] mcu_addr;
  logic [7:0]  mcu_wdata;
  logic [7:0]  mcu_rdata;
  logic        mcu_ack;
  logic [23:0] sram_addr;
  logic [7:0]  sram_dq_o;
  logic [7:0]  sram_dq_i;
  logic        sram_dq_oe;
  logic        sram_ce_n;
  logic        sram_oe_n;
  logic        sram_we_n;
  logic        busy;
  logic        snes_overrun;

  modport slave (
    input  snes_req, snes_we, snes_writable, snes_addr, snes_wdata,
    input  mcu_req, mcu_we, mcu_addr, mcu_wdata, sram_dq_i,
    output snes_rdata, snes_done, mcu_rdata, mcu_ack,
    output sram_addr, sram_dq_o, sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n,
    output busy, snes_overrun
  );

  modport master (
    output snes_req, snes_we, snes_writable, snes_addr, snes_wdata,
    output mcu_req, mcu_we, mcu_addr, mcu_wdata, sram_dq_i,
    input  snes_rdata, snes_done, mcu_rdata, mcu_ack,
    input  sram_addr, sram_dq_o, sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n,
    input  busy, snes_overrun
  );
endinterface

// File: rtl/sram_arbiter_access_seq.sv
// Access sequencer: runs one SRAM cycle (setup + strobe), then recovery, and
// exposes the slot in which a new access may be launched.
module sram_access_seq
  import sram_arb_pkg::*;
#(
  parameter int ACCESS_CYCLES  = ACCESS_CYCLES_DEF,
  parameter int RECOVER_CYCLES = RECOVER_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_start,
  input  acc_req_t    i_req,
  input  logic        i_owner,
  output logic        o_slot,
  output logic        o_last,
  output logic        o_sample,
  output logic        o_owner,
  output logic        o_busy,
  output logic        o_ce_n,
  output logic        o_oe_n,
  output logic        o_we_n,
  output logic        o_dq_oe,
  output logic [23:0] o_addr,
  output logic [7:0]  o_dq_o
);

  localparam int CNT_W = cnt_width(ACCESS_CYCLES);
  localparam int REC_W = cnt_width(RECOVER_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACCESS_CYCLES - 1);
  localparam logic [REC_W-1:0] REC_LAST = REC_W'(RECOVER_CYCLES - 1);

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [REC_W-1:0] r_rec;
  logic             r_owner, r_we, r_wr_en;
  logic [23:0]      r_addr;
  logic [7:0]       r_dq_o;
  logic             r_ce_n, r_oe_n, r_we_n, r_dq_oe, r_busy;

  logic [1:0]       w_state_n;
  logic [CNT_W-1:0] w_cnt_n;
  logic [REC_W-1:0] w_rec_n;
  logic             w_op_we, w_op_wr, w_launch, w_in_acc, w_rec_end, w_last;

  assign w_last    = (r_state == ST_ACCESS) && (r_cnt == CNT_LAST);
  assign w_rec_end = (r_state == ST_RECOVER) && (r_rec == REC_LAST);
  // The last recovery cycle doubles as an arbitration slot, giving back-to-back
  // accesses a period of ACCESS_CYCLES + RECOVER_CYCLES.
  assign o_slot    = (r_state == ST_IDLE) || w_rec_end;
  assign w_launch  = i_start && o_slot;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_rec_n   = r_rec;
    w_op_we   = r_we;
    w_op_wr   = r_wr_en;
    if (w_launch) begin
      w_state_n = ST_ACCESS;
      w_cnt_n   = '0;
      w_op_we   = i_req.we;
      w_op_wr   = i_req.wr_en;
    end else begin
      case (r_state)
        ST_ACCESS: begin
          if (w_last) begin
            w_state_n = ST_RECOVER;
            w_rec_n   = '0;
          end else begin
            w_cnt_n = r_cnt + 1'b1;
          end
        end
        ST_RECOVER: begin
          if (w_rec_end) w_state_n = ST_IDLE;
          else           w_rec_n   = r_rec + 1'b1;
        end
        default: w_state_n = ST_IDLE;
      endcase
    end
  end

  assign w_in_acc = (w_state_n == ST_ACCESS);

  // NOTE: reset is synchronous (sampled on the clock edge) and all state uses
  // non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_rec   <= '0;
      r_owner <= OWN_SNES;
      r_we    <= 1'b0;
      r_wr_en <= 1'b0;
      r_addr  <= '0;
      r_dq_o  <= '0;
      r_ce_n  <= 1'b1;
      r_oe_n  <= 1'b1;
      r_we_n  <= 1'b1;
      r_dq_oe <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_rec   <= w_rec_n;
      r_we    <= w_op_we;
      r_wr_en <= w_op_wr;
      r_ce_n  <= !w_in_acc;
      r_oe_n  <= !(w_in_acc && !w_op_we);
      r_we_n  <= !(w_in_acc && w_op_wr && (w_cnt_n != '0));
      r_dq_oe <= w_in_acc && w_op_wr;
      r_busy  <= (w_state_n != ST_IDLE);
      if (w_launch) begin
        r_addr  <= i_req.addr;
        r_dq_o  <= i_req.wdata;
        r_owner <= i_owner;
      end
    end
  end

  assign o_last   = w_last;
  assign o_sample = w_last && !r_we;
  assign o_owner  = r_owner;
  assign o_busy   = r_busy;
  assign o_ce_n   = r_ce_n;
  assign o_oe_n   = r_oe_n;
  assign o_we_n   = r_we_n;
  assign o_dq_oe  = r_dq_oe;
  assign o_addr   = r_addr;
  assign o_dq_o   = r_dq_o;

endmodule

// File: rtl/sram_arbiter.sv
// Cartridge SRAM arbiter: SNES (strict priority, one-deep buffer) versus MCU/DMA,
// with completion routing and held read data per requester.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ACCESS_CYCLES  = ACCESS_CYCLES_DEF,
  parameter int RECOVER_CYCLES = RECOVER_CYCLES_DEF
) (
  input logic          CLK,
  input logic          RST_N,
  sram_arbiter_if.slave bus
);

  logic     r_pend, r_overrun, r_snes_done, r_mcu_ack;
  acc_req_t r_pend_req;
  logic [7:0] r_snes_rdata, r_mcu_rdata;

  acc_req_t w_snes_live, w_mcu_live, w_req;
  logic     w_start, w_owner, w_slot, w_last, w_sample, w_seq_owner, w_mcu_ok;

  assign w_snes_live = '{addr: bus.snes_addr, wdata: bus.snes_wdata, we: bus.snes_we,
                         wr_en: bus.snes_we & bus.snes_writable};
  assign w_mcu_live  = '{addr: bus.mcu_addr, wdata: bus.mcu_wdata, we: bus.mcu_we,
                         wr_en: bus.mcu_we};
  // mcu_req is still high during its ack cycle, which can coincide with the next slot.
  assign w_mcu_ok    = bus.mcu_req && !r_mcu_ack;

  always_comb begin
    w_start = 1'b0;
    w_owner = OWN_SNES;
    w_req   = r_pend_req;
    if (w_slot) begin
      if (r_pend) begin
        w_start = 1'b1;
      end else if (bus.snes_req) begin
        w_start = 1'b1;
        w_req   = w_snes_live;
      end else if (w_mcu_ok) begin
        w_start = 1'b1;
        w_owner = OWN_MCU;
        w_req   = w_mcu_live;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_pend       <= 1'b0;
      r_pend_req   <= '0;
      r_overrun    <= 1'b0;
      r_snes_done  <= 1'b0;
      r_mcu_ack    <= 1'b0;
      r_snes_rdata <= '0;
      r_mcu_rdata  <= '0;
    end else begin
      if (w_slot && r_pend) r_pend <= 1'b0;
      if (bus.snes_req) begin
        if (r_pend) begin
          r_overrun <= 1'b1;
        end else if (!w_slot) begin
          r_pend     <= 1'b1;
          r_pend_req <= w_snes_live;
        end
      end
      r_snes_done <= w_last && (w_seq_owner == OWN_SNES);
      r_mcu_ack   <= w_last && (w_seq_owner == OWN_MCU);
      if (w_sample) begin
        if (w_seq_owner == OWN_MCU) r_mcu_rdata  <= bus.sram_dq_i;
        else                        r_snes_rdata <= bus.sram_dq_i;
      end
    end
  end

  sram_access_seq #(
    .ACCESS_CYCLES (ACCESS_CYCLES),
    .RECOVER_CYCLES(RECOVER_CYCLES)
  ) u_seq (
    .clk     (CLK),
    .rst_n   (RST_N),
    .i_start (w_start),
    .i_req   (w_req),
    .i_owner (w_owner),
    .o_slot  (w_slot),
    .o_last  (w_last),
    .o_sample(w_sample),
    .o_owner (w_seq_owner),
    .o_busy  (bus.busy),
    .o_ce_n  (bus.sram_ce_n),
    .o_oe_n  (bus.sram_oe_n),
    .o_we_n  (bus.sram_we_n),
    .o_dq_oe (bus.sram_dq_oe),
    .o_addr  (bus.sram_addr),
    .o_dq_o  (bus.sram_dq_o)
  );

  assign bus.snes_rdata   = r_snes_rdata;
  assign bus.snes_done    = r_snes_done;
  assign bus.mcu_rdata    = r_mcu_rdata;
  assign bus.mcu_ack      = r_mcu_ack;
  assign bus.snes_overrun = r_overrun;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: directed scenarios then random traffic, all compared
// cycle by cycle against a schedule-based reference model.
module tb_sram_arbiter;

  localparam int A = 4;
  localparam int R = 1;

  logic CLK = 1'b0;
  logic RST_N;
  always #5 CLK = ~CLK;

  sram_arbiter_if bus();

  sram_arbiter #(.ACCESS_CYCLES(A), .RECOVER_CYCLES(R)) dut (
    .CLK  (CLK),
    .RST_N(RST_N),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, act, exp);
    end
  endtask

  // Stimulus for the current cycle.
  logic        d_rst_n, d_snes_req, d_snes_we, d_snes_wr, d_mcu_req, d_mcu_we;
  logic [23:0] d_snes_addr, d_mcu_addr;
  logic [7:0]  d_snes_wdata, d_mcu_wdata, d_dq_i;

  // Reference model: each access started at cycle s drives the pads s+1..s+A,
  // completes at s+A+1, and the next arbitration slot is s+A+R.
  typedef struct {
    logic [23:0] addr;
    logic [7:0]  wdata;
    logic        we;
    logic        wr_en;
    logic        mcu;
    int          start;
  } acc_t;

  acc_t        cur, pend;
  bit          cur_valid, pend_valid, m_overrun;
  int          next_slot, snes_done_at, mcu_ack_at;
  logic [23:0] m_addr;
  logic [7:0]  m_dq_o, m_snes_rd, m_mcu_rd;

  task automatic model_reset();
    cur_valid    = 0;
    pend_valid   = 0;
    m_overrun    = 0;
    next_slot    = cyc + 1;
    snes_done_at = -100;
    mcu_ack_at   = -100;
    m_addr       = '0;
    m_dq_o       = '0;
    m_snes_rd    = '0;
    m_mcu_rd     = '0;
  endtask

  task automatic model_start(input acc_t a);
    cur       = a;
    cur.start = cyc;
    cur_valid = 1;
    next_slot = cyc + A + R;
    m_addr    = a.addr;
    m_dq_o    = a.wdata;
    if (a.mcu) mcu_ack_at   = cyc + A + 1;
    else       snes_done_at = cyc + A + 1;
  endtask

  task automatic model_step();
    acc_t live, mreq;
    if (!d_rst_n) begin
      model_reset();
      return;
    end
    if (cur_valid && cyc == cur.start + A && !cur.we) begin
      if (cur.mcu) m_mcu_rd  = d_dq_i;
      else         m_snes_rd = d_dq_i;
    end
    live.addr  = d_snes_addr;  live.wdata = d_snes_wdata;
    live.we    = d_snes_we;    live.wr_en = d_snes_we & d_snes_wr;
    live.mcu   = 1'b0;         live.start = 0;
    mreq.addr  = d_mcu_addr;   mreq.wdata = d_mcu_wdata;
    mreq.we    = d_mcu_we;     mreq.wr_en = d_mcu_we;
    mreq.mcu   = 1'b1;         mreq.start = 0;
    if (cyc >= next_slot) begin
      if (pend_valid) begin
        model_start(pend);
        pend_valid = 0;
        if (d_snes_req) m_overrun = 1;
      end else if (d_snes_req) begin
        model_start(live);
      end else if (d_mcu_req && cyc != mcu_ack_at) begin
        model_start(mreq);
      end
    end else if (d_snes_req) begin
      if (pend_valid) m_overrun = 1;
      else begin
        pend       = live;
        pend_valid = 1;
      end
    end
  endtask

  task automatic check_outputs();
    bit in_acc, busy;
    in_acc = cur_valid && cyc >= cur.start + 1 && cyc <= cur.start + A;
    busy   = cur_valid && cyc >= cur.start + 1 && cyc <= cur.start + A + R;
    check("ce_n",    32'(bus.sram_ce_n),    32'(!in_acc));
    check("oe_n",    32'(bus.sram_oe_n),    32'(!(in_acc && !cur.we)));
    check("we_n",    32'(bus.sram_we_n),    32'(!(in_acc && cur.wr_en && cyc >= cur.start + 2)));
    check("dq_oe",   32'(bus.sram_dq_oe),   32'(in_acc && cur.wr_en));
    check("addr",    32'(bus.sram_addr),    32'(m_addr));
    check("dq_o",    32'(bus.sram_dq_o),    32'(m_dq_o));
    check("done",    32'(bus.snes_done),    32'(cyc == snes_done_at));
    check("ack",     32'(bus.mcu_ack),      32'(cyc == mcu_ack_at));
    check("s_rdata", 32'(bus.snes_rdata),   32'(m_snes_rd));
    check("m_rdata", 32'(bus.mcu_rdata),    32'(m_mcu_rd));
    check("busy",    32'(bus.busy),         32'(busy));
    check("overrun", 32'(bus.snes_overrun), 32'(m_overrun));
  endtask

  task automatic run_cycle();
    if (d_mcu_req && cyc == mcu_ack_at + 1) d_mcu_req = 1'b0;
    RST_N             = d_rst_n;
    bus.snes_req      = d_snes_req;
    bus.snes_we       = d_snes_we;
    bus.snes_writable = d_snes_wr;
    bus.snes_addr     = d_snes_addr;
    bus.snes_wdata    = d_snes_wdata;
    bus.mcu_req       = d_mcu_req;
    bus.mcu_we        = d_mcu_we;
    bus.mcu_addr      = d_mcu_addr;
    bus.mcu_wdata     = d_mcu_wdata;
    bus.sram_dq_i     = d_dq_i;
    model_step();
    @(posedge CLK);
    #1;
    cyc++;
    check_outputs();
  endtask

  task automatic idle(input int n);
    d_snes_req = 1'b0;
    for (int i = 0; i < n; i++) run_cycle();
  endtask

  initial begin
    d_rst_n = 1'b0;  d_snes_req = 1'b0; d_snes_we = 1'b0; d_snes_wr = 1'b0;
    d_mcu_req = 1'b0; d_mcu_we = 1'b0;  d_snes_addr = '0; d_mcu_addr = '0;
    d_snes_wdata = '0; d_mcu_wdata = '0; d_dq_i = 8'hA5;
    model_reset();

    run_cycle();
    run_cycle();
    check("rst_ce_n", 32'(bus.sram_ce_n), 32'd1);
    check("rst_busy", 32'(bus.busy), 32'd0);
    d_rst_n = 1'b1;
    idle(2);

    // Single SNES read.
    d_snes_req = 1'b1; d_snes_we = 1'b0; d_snes_addr = 24'h123456;
    run_cycle();
    idle(6);
    check("rd_a5", 32'(bus.snes_rdata), 32'h0000_00A5);

    // SNES write, writable then suppressed.
    d_snes_req = 1'b1; d_snes_we = 1'b1; d_snes_wr = 1'b1; d_snes_wdata = 8'h3C;
    d_snes_addr = 24'h00F00D;
    run_cycle();
    idle(6);
    d_snes_req = 1'b1; d_snes_wr = 1'b0;
    run_cycle();
    idle(6);

    // Simultaneous SNES and MCU requests.
    d_snes_req = 1'b1; d_snes_we = 1'b0; d_snes_addr = 24'h000111;
    d_mcu_req = 1'b1; d_mcu_we = 1'b0; d_mcu_addr = 24'h00ABCD;
    run_cycle();
    idle(12);
    check("mcu_rd", 32'(bus.mcu_rdata), 32'h0000_00A5);

    // MCU write running; SNES buffered, then a second SNES request overruns.
    d_mcu_req = 1'b1; d_mcu_we = 1'b1; d_mcu_addr = 24'h0F0F0F; d_mcu_wdata = 8'h5A;
    run_cycle();
    idle(1);
    d_snes_req = 1'b1; d_snes_we = 1'b0; d_snes_addr = 24'h222222;
    run_cycle();
    d_snes_req = 1'b1; d_snes_addr = 24'h333333;
    run_cycle();
    idle(14);
    check("overrun_set", 32'(bus.snes_overrun), 32'd1);

    // Reset during the third ACCESS cycle of an MCU write with a buffered SNES request.
    d_mcu_req = 1'b1; d_mcu_we = 1'b1; d_mcu_addr = 24'h0A0B0C; d_mcu_wdata = 8'h77;
    run_cycle();
    idle(1);
    d_snes_req = 1'b1; d_snes_addr = 24'h444444;
    run_cycle();
    d_snes_req = 1'b0; d_rst_n = 1'b0;
    run_cycle();
    check("mid_rst_busy",  32'(bus.busy), 32'd0);
    check("mid_rst_dq_oe", 32'(bus.sram_dq_oe), 32'd0);
    check("mid_rst_ovr",   32'(bus.snes_overrun), 32'd0);
    d_rst_n = 1'b1; d_mcu_req = 1'b0;
    idle(8);

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      d_dq_i       = 8'($urandom);
      d_rst_n      = ($urandom_range(0, 399) != 0);
      d_snes_req   = ($urandom_range(0, 4) == 0);
      d_snes_we    = 1'($urandom);
      d_snes_wr    = 1'($urandom);
      d_snes_addr  = 24'($urandom);
      d_snes_wdata = 8'($urandom);
      if (!d_mcu_req && $urandom_range(0, 3) == 0) begin
        d_mcu_req   = 1'b1;
        d_mcu_we    = 1'($urandom);
        d_mcu_addr  = 24'($urandom);
        d_mcu_wdata = 8'($urandom);
      end
      run_cycle();
    end
    idle(10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
